// File: rtl/butterfly_pair_feeder.sv
// butterfly_pair_feeder: gathers a frame of N complex samples, then hands
// the radix-2 butterfly its operand pairs (x[i], x[i+N/2]) with twiddle
// index k = i, one pair per send handshake, in order i = 0..N/2-1.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// val && rdy are both 1. A producer holds val and its data stable until that
// edge. recv_rdy and send_val are decoded from the state register only, so
// neither depends combinationally on the opposite handshake input.
module butterfly_pair_feeder #(
  parameter int n = 32,
  parameter int N = 8,
  localparam int CW = $clog2(N),
  localparam int WW = (N > 2) ? $clog2(N / 2) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          recv_val,
  output logic          recv_rdy,
  input  logic [n-1:0]  recv_r,
  input  logic [n-1:0]  recv_c,
  output logic          send_val,
  input  logic          send_rdy,
  output logic [n-1:0]  ar,
  output logic [n-1:0]  ac,
  output logic [n-1:0]  br,
  output logic [n-1:0]  bc,
  output logic [WW-1:0] widx
);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic [WW-1:0] i;

  // Sample buffer: real and imaginary halves kept as separate arrays.
  logic [n-1:0] mem_r [N];
  logic [n-1:0] mem_c [N];

  logic          accept;
  logic          issue;
  logic [CW-1:0] a_idx;
  logic [CW-1:0] b_idx;

  assign recv_rdy = (state == FILL);
  assign send_val = (state == EMIT);
  assign accept   = recv_val && recv_rdy;
  assign issue    = send_val && send_rdy;

  // Pair i reads entries i and i+N/2 of the buffer.
  assign a_idx = CW'(i);
  assign b_idx = a_idx + CW'(N / 2);

  // Control: fill N samples, then walk the N/2 pairs; reset drops any
  // partial frame or remaining pairs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      wcnt  <= '0;
      i     <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == CW'(N - 1)) begin
              state <= EMIT;
              i     <= '0;
            end
          end
        end
        EMIT: begin
          if (issue) begin
            if (i == WW'(N / 2 - 1)) begin
              state <= FILL;
              i     <= '0;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        default: begin
          state <= FILL;
          wcnt  <= '0;
          i     <= '0;
        end
      endcase
    end
  end

  // Buffer write on every accepted sample; contents are not reset since
  // nothing is read until a whole frame has been written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_r[wcnt] <= recv_r;
      mem_c[wcnt] <= recv_c;
    end
  end

  // Operand outputs: buffer reads while emitting, forced to zero otherwise.
  always_comb begin
    ar   = '0;
    ac   = '0;
    br   = '0;
    bc   = '0;
    widx = '0;
    if (send_val) begin
      ar   = mem_r[a_idx];
      ac   = mem_c[a_idx];
      br   = mem_r[b_idx];
      bc   = mem_c[b_idx];
      widx = i;
    end
  end

endmodule

// File: tb/tb_butterfly_pair_feeder.sv
// Directed bench for butterfly_pair_feeder: an N=8 instance for the main
// scenarios and an N=2 instance for the degenerate one-pair frame.
module tb_butterfly_pair_feeder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=8 instance ----------------
  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [31:0] recv_r = '0;
  logic [31:0] recv_c = '0;
  logic        send_val;
  logic        send_rdy = 1'b0;
  logic [31:0] ar, ac, br, bc;
  logic [1:0]  widx;

  butterfly_pair_feeder #(.n(32), .N(8)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_r   (recv_r),
    .recv_c   (recv_c),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .ar       (ar),
    .ac       (ac),
    .br       (br),
    .bc       (bc),
    .widx     (widx)
  );

  // ---------------- N=2 instance ----------------
  logic        recv_val2 = 1'b0;
  logic        recv_rdy2;
  logic [31:0] recv_r2 = '0;
  logic [31:0] recv_c2 = '0;
  logic        send_val2;
  logic        send_rdy2 = 1'b0;
  logic [31:0] ar2, ac2, br2, bc2;
  logic [0:0]  widx2;

  butterfly_pair_feeder #(.n(32), .N(2)) u_dut2 (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val2),
    .recv_rdy (recv_rdy2),
    .recv_r   (recv_r2),
    .recv_c   (recv_c2),
    .send_val (send_val2),
    .send_rdy (send_rdy2),
    .ar       (ar2),
    .ac       (ac2),
    .br       (br2),
    .bc       (bc2),
    .widx     (widx2)
  );

  // Observation vectors: {send_val, recv_rdy, ar, ac, br, bc, widx}
  logic [131:0] obs;
  logic [130:0] obs2;
  assign obs  = {send_val, recv_rdy, ar, ac, br, bc, widx};
  assign obs2 = {send_val2, recv_rdy2, ar2, ac2, br2, bc2, widx2};

  localparam logic [131:0] IDLE  = {1'b0, 1'b1, 128'b0, 2'b0};
  localparam logic [130:0] IDLE2 = {1'b0, 1'b1, 128'b0, 1'b0};

  int total = 0;
  int bad   = 0;

  // ---------------- expected data ----------------
  // Basic frame: x[j] = (j.0, -j.0) in Q16.16.
  function automatic logic [31:0] bas_r(input int j);
    return 32'(j) << 16;
  endfunction
  function automatic logic [31:0] bas_c(input int j);
    return 32'd0 - (32'(j) << 16);
  endfunction
  // Second frame: x[j] = (0x7FFFFFFF - j, j).
  function automatic logic [31:0] f2_r(input int j);
    return 32'h7FFF_FFFF - 32'(j);
  endfunction
  function automatic logic [31:0] f2_c(input int j);
    return 32'(j);
  endfunction
  // Post-reset frame: x[j] = (0x100 + j, 0x200 + j).
  function automatic logic [31:0] f3_r(input int j);
    return 32'h100 + 32'(j);
  endfunction
  function automatic logic [31:0] f3_c(input int j);
    return 32'h200 + 32'(j);
  endfunction

  // ---------------- drivers ----------------
  // Present one sample and hold it until the edge where it is accepted.
  task automatic push(input logic [31:0] r, input logic [31:0] c);
    int waited;
    waited   = 0;
    recv_val = 1'b1;
    recv_r   = r;
    recv_c   = c;
    while (recv_rdy !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (recv_rdy !== 1'b1) begin
      bad++;
      $display("FAIL push_timeout got recv_rdy=%b exp=1", recv_rdy);
    end
    @(posedge clk); #1;
    recv_val = 1'b0;
  endtask

  task automatic push2(input logic [31:0] r, input logic [31:0] c);
    int waited;
    waited    = 0;
    recv_val2 = 1'b1;
    recv_r2   = r;
    recv_c2   = c;
    while (recv_rdy2 !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    total++;
    if (recv_rdy2 !== 1'b1) begin
      bad++;
      $display("FAIL push2_timeout got recv_rdy=%b exp=1", recv_rdy2);
    end
    @(posedge clk); #1;
    recv_val2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL reset_during got=%h exp=%h", obs, IDLE);
    end
    total++;
    if (obs2 !== IDLE2) begin
      bad++;
      $display("FAIL reset_during_n2 got=%h exp=%h", obs2, IDLE2);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL reset_after got=%h exp=%h", obs, IDLE);
    end
  endtask

  task automatic test_basic_frame;
    logic [131:0] exp_v;
    send_rdy = 1'b1;
    for (int j = 0; j < 8; j++) push(bas_r(j), bas_c(j));
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, bas_r(k), bas_c(k), bas_r(k + 4), bas_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL basic_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL basic_back_to_fill got=%h exp=%h", obs, IDLE);
    end
  endtask

  task automatic test_back_pressure;
    logic [131:0] exp_v;
    send_rdy = 1'b1;
    for (int j = 0; j < 8; j++) push(bas_r(j), bas_c(j));
    exp_v = {1'b1, 1'b0, bas_r(0), bas_c(0), bas_r(4), bas_c(4), 2'd0};
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL bp_pair0 got=%h exp=%h", obs, exp_v);
    end
    @(posedge clk); #1;
    send_rdy = 1'b0;
    exp_v = {1'b1, 1'b0, 32'h0001_0000, bas_c(1), 32'h0005_0000, bas_c(5), 2'd1};
    for (int s = 0; s < 5; s++) begin
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bp_stall%0d got=%h exp=%h", s, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    send_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, bas_r(k), bas_c(k), bas_r(k + 4), bas_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bp_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL bp_back_to_fill got=%h exp=%h", obs, IDLE);
    end
  endtask

  task automatic test_bubbly_input;
    logic [131:0] exp_v;
    send_rdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 7) begin
        total++;
        if (obs !== IDLE) begin
          bad++;
          $display("FAIL bubbly_still_fill got=%h exp=%h", obs, IDLE);
        end
      end
      push(bas_r(j), bas_c(j));
      if (j != 7) begin
        // Idle cycle with junk on the data bus that must not be stored.
        recv_r = 32'hDEAD_BEEF;
        recv_c = 32'hBAD0_CAFE;
        @(posedge clk); #1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, bas_r(k), bas_c(k), bas_r(k + 4), bas_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL bubbly_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    logic [131:0] exp_v;
    send_rdy = 1'b1;
    for (int j = 0; j < 8; j++) push(bas_r(j), bas_c(j));
    // Frame 2 first sample waits on the port throughout frame 1's EMIT.
    recv_val = 1'b1;
    recv_r   = f2_r(0);
    recv_c   = f2_c(0);
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, bas_r(k), bas_c(k), bas_r(k + 4), bas_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL b2b_f1_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (recv_rdy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_rdy_after_emit got=%b exp=1", recv_rdy);
    end
    for (int j = 0; j < 8; j++) push(f2_r(j), f2_c(j));
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, f2_r(k), f2_c(k), f2_r(k + 4), f2_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL b2b_f2_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset;
    logic [131:0] exp_v;
    send_rdy = 1'b1;
    for (int j = 0; j < 8; j++) push(bas_r(j), bas_c(j));
    @(posedge clk); #1;   // pair 0 handshaked
    @(posedge clk); #1;   // pair 1 handshaked, pair 2 on the port
    total++;
    if (widx !== 2'd2) begin
      bad++;
      $display("FAIL areset_pre_widx got=%0d exp=2", widx);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL areset_immediate got=%h exp=%h", obs, IDLE);
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 8; j++) push(f3_r(j), f3_c(j));
    for (int k = 0; k < 4; k++) begin
      exp_v = {1'b1, 1'b0, f3_r(k), f3_c(k), f3_r(k + 4), f3_c(k + 4), 2'(k)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL areset_pair%0d got=%h exp=%h", k, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (obs !== IDLE) begin
      bad++;
      $display("FAIL areset_back_to_fill got=%h exp=%h", obs, IDLE);
    end
  endtask

  task automatic test_n2;
    logic [130:0] exp_v;
    send_rdy2 = 1'b1;
    push2(32'h0001_0000, 32'h0);
    total++;
    if (obs2 !== IDLE2) begin
      bad++;
      $display("FAIL n2_after_first got=%h exp=%h", obs2, IDLE2);
    end
    push2(32'hFFFF_0000, 32'h0);
    exp_v = {1'b1, 1'b0, 32'h0001_0000, 32'h0, 32'hFFFF_0000, 32'h0, 1'b0};
    total++;
    if (obs2 !== exp_v) begin
      bad++;
      $display("FAIL n2_pair got=%h exp=%h", obs2, exp_v);
    end
    @(posedge clk); #1;
    total++;
    if (obs2 !== IDLE2) begin
      bad++;
      $display("FAIL n2_back_to_fill got=%h exp=%h", obs2, IDLE2);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_basic_frame;
    test_back_pressure;
    test_bubbly_input;
    test_back_to_back;
    test_async_reset;
    test_n2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/butterfly_pair_feeder.md
Name: butterfly_pair_feeder

Overview:
- Upstream stage of the radix-2 butterfly unit.
- Collects a frame of N complex fixed-point samples arriving serially over a val/rdy stream.
- Then issues N/2 butterfly operand pairs (a = x[i], b = x[i+N/2]) with twiddle index k = i over a val/rdy stream.
- Its send port connects directly to the butterfly's recv_val/recv_rdy and a/b operand ports; widx drives the external twiddle table that supplies wr/wc.

Parameters:
- n, 32, bit width of each real/imag component (fixed point, d fractional bits; feeder is arithmetic-free, so d is not needed).
- N, 8, frame length in complex samples; power of two, N >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- recv_val  input  1  upstream sample valid.
- recv_rdy  output  1  feeder can accept a sample.
- recv_r  input  n  sample real part.
- recv_c  input  n  sample imaginary part.
- send_val  output  1  butterfly pair valid.
- send_rdy  input  1  butterfly ready to accept pair.
- ar  output  n  operand a real = buf[i].r.
- ac  output  n  operand a imag = buf[i].c.
- br  output  n  operand b real = buf[i+N/2].r.
- bc  output  n  operand b imag = buf[i+N/2].c.
- widx  output  max(1,log2(N/2))  twiddle index k = i.

Behaviour:
- Storage: N-entry buffer of {r,c} registers (2n bits each); write counter wcnt (log2 N bits); pair counter i (log2(N/2) bits, 1 bit when N=2); state register.
- Reset (async, immediate): state=FILL, wcnt=0, i=0, recv_rdy=1, send_val=0, ar/ac/br/bc/widx=0. Buffer contents need not be cleared. Reset mid-frame discards the partial frame; reset mid-emit drops the remaining pairs. No partial pair is ever emitted after reset.
- FILL:
  - recv_rdy=1, send_val=0, operand outputs and widx forced 0.
  - On a cycle with recv_val && recv_rdy: buf[wcnt] <= {recv_r, recv_c}; wcnt <= wcnt+1 (wraps to 0).
  - When the accepted sample is at wcnt==N-1: next state EMIT, i <= 0.
  - recv_val with no transfer leaves everything unchanged.
- EMIT:
  - recv_rdy=0 (new samples are back-pressured); send_val=1.
  - ar/ac = buf[i], br/bc = buf[i+N/2], widx = i, all driven from registers (combinational read of the registered buffer and i only).
  - Outputs hold stable while send_val && !send_rdy.
  - On send_val && send_rdy: if i==N/2-1, next state FILL, i<=0, wcnt already 0; else i <= i+1.
- Latency: send_val rises the cycle after the N-th sample handshake. First pair available 1 cycle after frame completes. One pair per cycle when send_rdy is held high, so EMIT lasts N/2 cycles minimum. recv_rdy rises the cycle after the last pair handshake.
- Throughput (single buffer, no overlap): N accepts + N/2 emits = 3N/2 cycles per frame minimum.
- No combinational path from recv_val to recv_rdy, or from send_rdy to send_val.
- Data passes bit-exact; no arithmetic, rounding or sign handling.
- Order: pairs are emitted strictly in i = 0..N/2-1. Frame k+1 samples never overwrite frame k before its last pair handshakes.

Test Plan:
- Basic frame, N=8, samples x[j] = (j<<16, -(j<<16)) (i.e. j.0, -j.0 with d=16), send_rdy=1 -> 4 pairs on consecutive cycles starting 1 cycle after 8th accept: (ar,br,widx) = (0x00000000,0x00040000,0), (0x00010000,0x00050000,1), (0x00020000,0x00060000,2), (0x00030000,0x00070000,3); ac/bc are the negated values; recv_rdy=0 throughout EMIT.
- Back-pressure: hold send_rdy=0 for 5 cycles at pair i=1 -> send_val stays 1, ar=0x00010000, br=0x00050000, widx=1 stable all 5 cycles; i advances only on the handshake cycle.
- Bubbly input: recv_val toggles 1,0,1,0 across the frame -> only handshake cycles store samples; emitted pairs match the basic-frame values; EMIT entry delayed accordingly.
- Back-to-back frames: second frame x[j] = 0x7FFFFFFF - j queued with recv_val=1 continuously -> recv_rdy=0 during EMIT of frame 1; frame 2 accepted from the cycle after frame 1's last pair; frame 2 pairs correct, no corruption of frame 1 values.
- Async reset mid-emit, after pair i=1 handshake: assert reset between clock edges -> send_val, ar..bc, widx go 0 immediately; recv_rdy=1. A fresh 8-sample frame then produces widx sequence 0..3 from its own data only.
- N=2 configuration: samples (0x00010000,0) and (0xFFFF0000,0) -> exactly one pair ar=0x00010000, br=0xFFFF0000, widx=0, then return to FILL.
